// File: rtl/sprite_line_buffer_dbl_if.sv
// Renderer / composer bus of the double-buffered sprite line buffer.
// The line buffer itself takes the slave modport.
interface sprite_line_buffer_dbl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 10
);
  logic                  swap_req;
  logic                  swap_ack;
  logic                  active_render_buffer;
  logic [IDX_WIDTH-1:0]  renderer_rd_idx;
  logic [DATA_WIDTH-1:0] renderer_rd_data;
  logic [IDX_WIDTH-1:0]  renderer_wr_idx;
  logic [DATA_WIDTH-1:0] renderer_wr_data;
  logic                  renderer_wr_en;
  logic [IDX_WIDTH-1:0]  composer_rd_idx;
  logic [DATA_WIDTH-1:0] composer_rd_data;
  logic                  composer_erase_start;
  logic                  erase_busy;

  modport master (
    output swap_req,
    output renderer_rd_idx,
    output renderer_wr_idx,
    output renderer_wr_data,
    output renderer_wr_en,
    output composer_rd_idx,
    output composer_erase_start,
    input  swap_ack,
    input  active_render_buffer,
    input  renderer_rd_data,
    input  composer_rd_data,
    input  erase_busy
  );

  modport slave (
    input  swap_req,
    input  renderer_rd_idx,
    input  renderer_wr_idx,
    input  renderer_wr_data,
    input  renderer_wr_en,
    input  composer_rd_idx,
    input  composer_erase_start,
    output swap_ack,
    output active_render_buffer,
    output renderer_rd_data,
    output composer_rd_data,
    output erase_busy
  );
endinterface

// File: rtl/sprite_line_buffer_dbl.sv
// Double-buffered, banked sprite line buffer with swap handshake,
// background line erase and clipping of out-of-range render writes.
module dpram #(
  parameter int DW    = 16,
  parameter int AW    = 8,
  parameter int DEPTH = 160
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic [AW-1:0] ra_i,
  output logic [DW-1:0] rd_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_q;

  // read-before-write: a same-row read returns the old word
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
    rd_q <= mem_q[ra_i];
  end

  assign rd_o = rd_q;
endmodule

module sprite_line_buffer_dbl #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 10,
  parameter int LINE_LEN   = 640,
  parameter int NUM_BANKS  = 4,
  parameter logic [DATA_WIDTH-1:0] ERASE_VALUE = '0
) (
  input logic clk,
  input logic rst,
  sprite_line_buffer_dbl_if.slave bus
);
  localparam int ROWS = LINE_LEN / NUM_BANKS;
  localparam int CW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);
  localparam logic [IDX_WIDTH-1:0] NB_I = IDX_WIDTH'(NUM_BANKS);
  localparam logic [IDX_WIDTH:0] LEN_I = (IDX_WIDTH + 1)'(LINE_LEN);

  typedef enum logic {
    IDLE,
    ERASE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tgt_q, tgt_d;
  logic          act_q;
  logic          pend_q, pend_d;
  logic          ack_q;
  logic          vld_q;
  logic          busy;
  logic          start;
  logic          swap_now;
  logic          wr_ok;

  logic          rr_buf_q, cr_buf_q;
  logic [BW-1:0] rr_bank_q, cr_bank_q;

  logic                  ram_we [2][NUM_BANKS];
  logic [CW-1:0]         ram_wa [2][NUM_BANKS];
  logic [DATA_WIDTH-1:0] ram_wd [2][NUM_BANKS];
  logic [CW-1:0]         ram_ra [2];
  logic [DATA_WIDTH-1:0] ram_rd [2][NUM_BANKS];

  function automatic logic [CW-1:0] row_of(
    input logic [IDX_WIDTH-1:0] idx
  );
    return CW'(idx / NB_I);
  endfunction

  function automatic logic [BW-1:0] bank_of(
    input logic [IDX_WIDTH-1:0] idx
  );
    return BW'(idx % NB_I);
  endfunction

  assign start = bus.composer_erase_start;
  assign busy  = (state_q == ERASE);
  assign wr_ok = bus.renderer_wr_en &&
                 ({1'b0, bus.renderer_wr_idx} < LEN_I);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ERASE;
          cnt_d   = '0;
          tgt_d   = ~act_q;
        end
      end
      ERASE: begin
        if (start) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ROW) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a swap waits for an idle FSM; repeated requests collapse into one
  assign swap_now = !busy && !start &&
                    (bus.swap_req || pend_q);
  assign pend_d   = !swap_now &&
                    (pend_q || bus.swap_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      act_q   <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      act_q   <= act_q ^ swap_now;
      pend_q  <= pend_d;
      ack_q   <= swap_now;
      vld_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    rr_buf_q  <= act_q;
    cr_buf_q  <= ~act_q;
    rr_bank_q <= bank_of(bus.renderer_rd_idx);
    cr_bank_q <= bank_of(bus.composer_rd_idx);
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      ram_ra[b] = (act_q == 1'(b)) ?
                  row_of(bus.renderer_rd_idx) :
                  row_of(bus.composer_rd_idx);
      for (int k = 0; k < NUM_BANKS; k++) begin
        ram_we[b][k] = 1'b0;
        ram_wa[b][k] = row_of(bus.renderer_wr_idx);
        ram_wd[b][k] = bus.renderer_wr_data;
        unique case (1'b1)
          (busy && !rst && tgt_q == 1'(b)): begin
            ram_we[b][k] = 1'b1;
            ram_wa[b][k] = cnt_q;
            ram_wd[b][k] = ERASE_VALUE;
          end
          (wr_ok && act_q == 1'(b) &&
           bank_of(bus.renderer_wr_idx) == BW'(k)): begin
            ram_we[b][k] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
      dpram #(
        .DW   (DATA_WIDTH),
        .AW   (CW),
        .DEPTH(ROWS)
      ) u_ram (
        .clk_i(clk),
        .we_i (ram_we[b][k]),
        .wa_i (ram_wa[b][k]),
        .wd_i (ram_wd[b][k]),
        .ra_i (ram_ra[b]),
        .rd_o (ram_rd[b][k])
      );
    end
  end

  assign bus.renderer_rd_data =
    vld_q ? ram_rd[rr_buf_q][rr_bank_q] : '0;
  assign bus.composer_rd_data =
    vld_q ? ram_rd[cr_buf_q][cr_bank_q] : '0;
  assign bus.swap_ack             = ack_q;
  assign bus.active_render_buffer = act_q;
  assign bus.erase_busy           = busy;
endmodule

// File: tb/tb_sprite_line_buffer_dbl.sv
// Bench for sprite_line_buffer_dbl: a default 640x4 instance and an
// 8-bank instance with a non-zero erase value, against a line model.
module tb_sprite_line_buffer_dbl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_line_buffer_dbl_if #(16, 10) a ();
  sprite_line_buffer_dbl_if #(16, 10) b ();

  sprite_line_buffer_dbl #(
    .DATA_WIDTH(16), .IDX_WIDTH(10), .LINE_LEN(640),
    .NUM_BANKS(4), .ERASE_VALUE(16'h0000)
  ) dut_a (.clk(clk), .rst(rst), .bus(a));

  sprite_line_buffer_dbl #(
    .DATA_WIDTH(16), .IDX_WIDTH(10), .LINE_LEN(640),
    .NUM_BANKS(8), .ERASE_VALUE(16'h00FF)
  ) dut_b (.clk(clk), .rst(rst), .bus(b));

  int errors = 0;
  int checks = 0;
  logic [15:0] ma [2][640];
  bit ka [2][640];
  int act = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_wr(input int idx, input logic [15:0] d);
    a.renderer_wr_en   = 1'b1;
    a.renderer_wr_idx  = 10'(idx);
    a.renderer_wr_data = d;
    tick();
    a.renderer_wr_en = 1'b0;
    if (idx < 640) begin
      ma[act][idx] = d;
      ka[act][idx] = 1'b1;
    end
  endtask

  task automatic a_rd(input int idx);
    a.renderer_rd_idx = 10'(idx);
    a.composer_rd_idx = 10'(idx);
    tick();
    if (ka[act][idx])
      chk("rend_rd", 32'(a.renderer_rd_data), 32'(ma[act][idx]));
    if (ka[1-act][idx])
      chk("comp_rd", 32'(a.composer_rd_data), 32'(ma[1-act][idx]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int ec;
    logic [15:0] pat;
    rst = 1'b1;
    a.swap_req = 0; a.renderer_rd_idx = 0; a.renderer_wr_idx = 0;
    a.renderer_wr_data = 0; a.renderer_wr_en = 0;
    a.composer_rd_idx = 0; a.composer_erase_start = 0;
    b.swap_req = 0; b.renderer_rd_idx = 0; b.renderer_wr_idx = 0;
    b.renderer_wr_data = 0; b.renderer_wr_en = 0;
    b.composer_rd_idx = 0; b.composer_erase_start = 0;
    repeat (3) tick();
    chk("rst_rrd", 32'(a.renderer_rd_data), 0);
    chk("rst_crd", 32'(a.composer_rd_data), 0);
    chk("rst_act", 32'(a.active_render_buffer), 0);
    chk("rst_ack", 32'(a.swap_ack), 0);
    chk("rst_busy", 32'(a.erase_busy), 0);
    chk("rst_b_rrd", 32'(b.renderer_rd_data), 0);
    chk("rst_b_crd", 32'(b.composer_rd_data), 0);
    chk("rst_b_act", 32'(b.active_render_buffer), 0);
    chk("rst_b_busy", 32'(b.erase_busy), 0);
    rst = 1'b0;
    tick();

    a_wr(5, 16'h1234);
    a_rd(5);
    a.renderer_wr_en = 1; a.renderer_wr_idx = 5;
    a.renderer_wr_data = 16'hBEEF; a.renderer_rd_idx = 5;
    tick();
    a.renderer_wr_en = 0;
    chk("raw_old", 32'(a.renderer_rd_data), 32'h1234);
    ma[0][5] = 16'hBEEF;
    a_rd(5);

    a_wr(60, 16'h0060);
    a_wr(700, 16'hFFFF);
    a_wr(1023, 16'hFFFF);
    a_wr(640, 16'hFFFF);
    a_rd(60);
    a_rd(5);

    for (int i = 0; i < 640; i++) a_wr(i, 16'(i));

    a.swap_req = 1; a.renderer_wr_en = 1;
    a.renderer_wr_idx = 639; a.renderer_wr_data = 16'h0AAA;
    a.renderer_rd_idx = 7;
    tick();
    a.swap_req = 0; a.renderer_wr_en = 0;
    ma[0][639] = 16'h0AAA;
    chk("swap_rd_pre", 32'(a.renderer_rd_data), 7);
    chk("swap_ack", 32'(a.swap_ack), 1);
    chk("swap_act", 32'(a.active_render_buffer), 1);
    act = 1;
    tick();
    chk("swap_ack_drop", 32'(a.swap_ack), 0);
    for (int i = 0; i < 640; i++) a_rd(i);

    for (int n = 0; n < 400; n++) begin
      int wi, ri, ci;
      bit we, rk;
      logic [15:0] wd, re, ce;
      we = 1'($urandom_range(0, 1));
      wi = ($urandom_range(0, 9) == 0) ?
           int'($urandom_range(640, 1023)) :
           int'($urandom_range(0, 63));
      wd = 16'($urandom);
      ri = int'($urandom_range(0, 63));
      ci = int'($urandom_range(0, 639));
      a.renderer_wr_en = we; a.renderer_wr_idx = 10'(wi);
      a.renderer_wr_data = wd;
      a.renderer_rd_idx = 10'(ri); a.composer_rd_idx = 10'(ci);
      rk = ka[1][ri]; re = ma[1][ri]; ce = ma[0][ci];
      if (we && wi < 640) begin
        ma[1][wi] = wd; ka[1][wi] = 1'b1;
      end
      tick();
      if (rk) chk("rnd_rend", 32'(a.renderer_rd_data), 32'(re));
      chk("rnd_comp", 32'(a.composer_rd_data), 32'(ce));
    end
    a.renderer_wr_en = 0;

    a.composer_erase_start = 1;
    tick();
    a.composer_erase_start = 0;
    ec = 0;
    while (a.erase_busy === 1'b1 && ec < 1000) begin
      ec++;
      tick();
    end
    chk("erase_len_4b", 32'(ec), 160);
    for (int i = 0; i < 640; i++) ma[0][i] = 16'h0000;
    for (int n = 0; n < 64; n++) a_rd(int'($urandom_range(0, 639)));
    a_rd(639);

    a.composer_erase_start = 1;
    tick();
    a.composer_erase_start = 0;
    ec = 0;
    while (a.erase_busy === 1'b1 && ec < 1000) begin
      a.swap_req = (ec == 10 || ec == 20 || ec == 30);
      tick();
      ec++;
      if (a.erase_busy === 1'b1)
        chk("pend_hold", 32'(a.active_render_buffer), 1);
    end
    a.swap_req = 0;
    chk("pend_erase_len", 32'(ec), 160);
    chk("pend_act_idle", 32'(a.active_render_buffer), 1);
    chk("pend_ack_idle", 32'(a.swap_ack), 0);
    tick();
    chk("pend_act_tog", 32'(a.active_render_buffer), 0);
    chk("pend_ack", 32'(a.swap_ack), 1);
    tick();
    chk("pend_ack_once", 32'(a.swap_ack), 0);
    chk("pend_act_keep", 32'(a.active_render_buffer), 0);
    act = 0;

    a.swap_req = 1;
    tick();
    chk("b2b_ack1", 32'(a.swap_ack), 1);
    chk("b2b_act1", 32'(a.active_render_buffer), 1);
    tick();
    a.swap_req = 0;
    chk("b2b_ack2", 32'(a.swap_ack), 1);
    chk("b2b_act2", 32'(a.active_render_buffer), 0);
    tick();
    chk("b2b_ack_end", 32'(a.swap_ack), 0);

    for (int i = 0; i < 640; i++) a_wr(i, 16'(i) ^ 16'h5A5A);
    a.swap_req = 1;
    tick();
    a.swap_req = 0;
    act = 1;
    tick();
    a.composer_erase_start = 1;
    tick();
    a.composer_erase_start = 0;
    for (int k = 0; k < 50; k++) begin
      a.swap_req = (k == 20);
      tick();
    end
    a.swap_req = 0;
    rst = 1;
    tick();
    chk("mid_rst_busy", 32'(a.erase_busy), 0);
    chk("mid_rst_act", 32'(a.active_render_buffer), 0);
    chk("mid_rst_rrd", 32'(a.renderer_rd_data), 0);
    chk("mid_rst_crd", 32'(a.composer_rd_data), 0);
    rst = 0;
    act = 0;
    for (int i = 0; i < 640; i++) begin
      pat = 16'(i) ^ 16'h5A5A;
      ma[0][i] = (i / 4 < 50) ? 16'h0000 : pat;
    end
    repeat (4) tick();
    chk("mid_rst_nopend", 32'(a.active_render_buffer), 0);
    chk("mid_rst_noack", 32'(a.swap_ack), 0);
    for (int i = 0; i < 640; i++) a_rd(i);

    b.renderer_wr_en = 1; b.renderer_wr_idx = 13;
    b.renderer_wr_data = 16'h1313;
    tick();
    b.renderer_wr_idx = 10'd653; b.renderer_wr_data = 16'hDEAD;
    tick();
    b.renderer_wr_en = 0; b.renderer_rd_idx = 13;
    tick();
    chk("b_wr13", 32'(b.renderer_rd_data), 32'h1313);
    b.composer_erase_start = 1;
    tick();
    b.composer_erase_start = 0;
    ec = 0;
    while (b.erase_busy === 1'b1 && ec < 1000) begin
      ec++;
      tick();
    end
    chk("erase_len_8b", 32'(ec), 80);
    for (int n = 0; n < 32; n++) begin
      int ci;
      ci = int'($urandom_range(0, 639));
      b.composer_rd_idx = 10'(ci);
      tick();
      chk("b_erase_val", 32'(b.composer_rd_data), 32'h00FF);
    end
    b.swap_req = 1;
    tick();
    b.swap_req = 0;
    chk("b_swap_act", 32'(b.active_render_buffer), 1);
    b.composer_rd_idx = 13; b.renderer_rd_idx = 10'd100;
    tick();
    chk("b_comp13", 32'(b.composer_rd_data), 32'h1313);
    chk("b_rend_ev", 32'(b.renderer_rd_data), 32'h00FF);
    b.composer_rd_idx = 10'd653 - 10'd640;
    tick();
    chk("b_clip", 32'(b.composer_rd_data), 32'h1313);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_line_buffer_dbl.md
Name: sprite_line_buffer_dbl

Overview:
Parametrised double-buffered sprite line buffer, the successor to the fixed 640x16 four-bank buffer. The sprite renderer builds line N+1 in one buffer while the composer reads line N from the other. Adds internal buffer-swap control with a handshake, configurable bank count, width, length and erase value, an erase-busy status, and out-of-range write clipping. Sits between the sprite renderer and the layer composer. Built on dpram instances, one per bank per buffer.

Parameters:
DATA_WIDTH, 16, pixel entry width (colour index plus priority bits)
IDX_WIDTH, 10, pixel index width
LINE_LEN, 640, entries per line; must be a multiple of NUM_BANKS
NUM_BANKS, 4, banks per buffer (power of 2, 1..8); erase clears NUM_BANKS entries per cycle
ERASE_VALUE, 0, value written by erase

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
swap_req  in  1  pulse: exchange the render and composer buffers
swap_ack  out  1  one-cycle pulse in the cycle after the swap takes effect
active_render_buffer  out  1  buffer currently owned by the renderer (0 or 1)
renderer_rd_idx  in  IDX_WIDTH  renderer read index
renderer_rd_data  out  DATA_WIDTH  renderer read data, 1-cycle latency
renderer_wr_idx  in  IDX_WIDTH  renderer write index
renderer_wr_data  in  DATA_WIDTH  renderer write data
renderer_wr_en  in  1  renderer write strobe
composer_rd_idx  in  IDX_WIDTH  composer read index
composer_rd_data  out  DATA_WIDTH  composer read data, 1-cycle latency
composer_erase_start  in  1  pulse: erase the composer-side buffer
erase_busy  out  1  erase in progress

Behaviour:
- Reset: active_render_buffer=0, swap_ack=0, erase_busy=0, swap pending cleared. Both rd_data outputs read 0 until the first read completes after reset. RAM contents are undefined after reset.
- Banking: entry i lives in bank i mod NUM_BANKS at row i/NUM_BANKS. The bank-select bits for each read port are registered with the address.
- Read data is always returned from the buffer that was selected in the issue cycle. A swap between issue and return does not redirect it.
- Reads: every cycle, 1-cycle latency. A renderer read of an address being written in the same cycle returns the old data.
- Render writes:
  - go to the active render buffer, only the addressed bank.
  - renderer_wr_en with renderer_wr_idx >= LINE_LEN is dropped; no RAM is modified.
- Erase FSM, states IDLE and ERASE. The erase counter is clog2(LINE_LEN/NUM_BANKS) wide.
  - IDLE, on composer_erase_start: target = composer buffer as sampled this cycle; counter=0; go to ERASE.
  - ERASE: each cycle write ERASE_VALUE to all NUM_BANKS banks of the target at row=counter. On row LINE_LEN/NUM_BANKS-1, go to IDLE.
  - erase_busy is high in every cycle the FSM is in ERASE. An erase takes exactly LINE_LEN/NUM_BANKS cycles.
  - composer_erase_start while in ERASE restarts the counter at 0. The target stays unchanged.
  - Composer reads during an erase are allowed and return the old or erased value, depending on whether that row has been erased yet.
- Swap:
  - swap_req sampled in cycle n with FSM in IDLE and no erase_start: active_render_buffer toggles at n+1 and swap_ack=1 in n+1.
  - Render writes in cycle n still go to the old buffer.
  - swap_req while erase_busy, or coinciding with composer_erase_start, sets a pending flag. The swap executes in the first cycle after the FSM returns to IDLE; swap_ack follows one cycle later.
  - Further swap_req pulses while a swap is pending are merged (one swap only).
  - swap_req in the same cycle as swap_ack is treated as a new request.
- Reset asserted mid-erase or mid-pending aborts both immediately. Rows not yet erased keep their contents.

Test Plan:
1. Defaults, after reset: write 0x1234 at idx 5, read renderer idx 5 -> 0x1234 next cycle. Composer read idx 5 -> not 0x1234 (other buffer). Before any read, both rd_data outputs read 0.
2. Write idx 700 (>=640) with 0xFFFF -> no RAM change. A read of idx 700 mod 1024 aliasing rows still returns its prior value.
3. Fill render buffer 0..639 with idx values, swap_req -> swap_ack one cycle later, active_render_buffer=1. Composer reads 0..639 return 0..639.
4. composer_erase_start -> erase_busy high exactly 160 cycles. Composer reads 0..639 afterwards return 0. A buffer built with ERASE_VALUE=0x00FF returns 0x00FF.
5. swap_req at erase cycle 10 -> no toggle until erase_busy falls. Toggle occurs one cycle later and swap_ack pulses once, even with 3 swap_req pulses during the erase.
6. Read issued in the cycle of swap_req -> data returned is from the pre-swap buffer. Reset asserted at erase cycle 50 -> erase_busy=0 next cycle and rows 50..159 hold old data. With NUM_BANKS=8, LINE_LEN=640, erase takes 80 cycles.
